pipeline_hazard_controller: RTL and testbench

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

---
 rtl/pipeline_hazard_controller_pkg.sv | 32 +++
 rtl/pipeline_hazard_controller_if.sv | 25 ++
 rtl/pipeline_hazard_controller_sat_counter.sv | 26 ++
 rtl/pipeline_hazard_controller.sv | 147 ++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared state encoding, applied-action codes and parameter defaults
// for the pipeline hazard controller.
package pipeline_ctrl_pkg;

  localparam int CNT_W_DEF          = 16;
  localparam int TIMEOUT_CYCLES_DEF = 255;
  localparam int DRAIN_CYCLES_DEF   = 4;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_FREEZE,
    ACT_FLUSH,
    ACT_STALL,
    ACT_BUBBLE,
    ACT_HOLD
  } action_t;

  function automatic logic load_use(input logic       mem_read,
                                    input logic [4:0] rd,
                                    input logic [4:0] rs1,
                                    input logic [4:0] rs2);
    return mem_read && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Pipeline-side bundle: hazard and memory status in, stage control out.
interface pipeline_hazard_controller_if;
  logic       MemRead_IDEX;
  logic [4:0] rd_IDEX;
  logic [4:0] rs1_IFID;
  logic [4:0] rs2_IFID;
  logic       PCSrcE;
  logic       dmem_req;
  logic       dmem_ready;
  logic       PCWrite;
  logic       Write_IFID;
  logic       Flush_IFID;
  logic       Flush_IDEX;
  logic       freeze_all;

  modport master (
    output MemRead_IDEX, rd_IDEX, rs1_IFID, rs2_IFID, PCSrcE, dmem_req, dmem_ready,
    input  PCWrite, Write_IFID, Flush_IFID, Flush_IDEX, freeze_all
  );

  modport slave (
    input  MemRead_IDEX, rd_IDEX, rs1_IFID, rs2_IFID, PCSrcE, dmem_req, dmem_ready,
    output PCWrite, Write_IFID, Flush_IFID, Flush_IDEX, freeze_all
  );
endinterface

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Hazard/stall/flush controller with memory-wait watchdog, debug halt drain
// sequence and saturating performance counters.
module pipeline_hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W          = CNT_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int DRAIN_CYCLES   = DRAIN_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipeline_hazard_controller_if.slave hz,
  input  logic                 halt_req,
  input  logic                 clr_counters,
  output logic                 halt_ack,
  output logic                 mem_timeout,
  output logic [CNT_W-1:0]     stall_count,
  output logic [CNT_W-1:0]     flush_count,
  output logic [1:0]           state
);

  localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam int WW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  state_t          state_reg, state_next;
  action_t         act;
  logic [DW-1:0]   drain_reg, drain_next, drain_inc;
  logic [WW-1:0]   wait_reg, wait_next;
  logic            halt_ack_reg, timeout_reg;
  logic            mw, br, lu;

  assign mw = hz.dmem_req & ~hz.dmem_ready;
  assign br = hz.PCSrcE;
  assign lu = load_use(hz.MemRead_IDEX, hz.rd_IDEX, hz.rs1_IFID, hz.rs2_IFID);
  assign drain_inc = drain_reg + 1'b1;

  always_comb begin
    act            = ACT_NONE;
    state_next     = state_reg;
    drain_next     = '0;
    hz.PCWrite     = 1'b1;
    hz.Write_IFID  = 1'b1;
    hz.Flush_IFID  = 1'b0;
    hz.Flush_IDEX  = 1'b0;
    hz.freeze_all  = 1'b0;

    // A finished memory wait falls through to the normal RUN priority.
    case (state_reg)
      RUN:      act = mw ? ACT_FREEZE : br ? ACT_FLUSH : lu ? ACT_STALL : ACT_NONE;
      MEM_WAIT: act = mw ? ACT_FREEZE : br ? ACT_FLUSH : lu ? ACT_STALL : ACT_NONE;
      DRAIN:    act = mw ? ACT_FREEZE : br ? ACT_FLUSH : lu ? ACT_STALL : ACT_BUBBLE;
      HALTED:   act = ACT_HOLD;
      default:  act = ACT_NONE;
    endcase

    case (act)
      ACT_FREEZE: begin
        hz.freeze_all = 1'b1;
        hz.PCWrite    = 1'b0;
        hz.Write_IFID = 1'b0;
      end
      ACT_FLUSH: begin
        hz.Flush_IFID = 1'b1;
        hz.Flush_IDEX = 1'b1;
      end
      ACT_STALL, ACT_HOLD: begin
        hz.PCWrite    = 1'b0;
        hz.Write_IFID = 1'b0;
        hz.Flush_IDEX = 1'b1;
      end
      ACT_BUBBLE: begin
        hz.PCWrite    = 1'b0;
        hz.Flush_IFID = 1'b1;
      end
      default: ;
    endcase

    case (state_reg)
      RUN: begin
        if (mw)            state_next = MEM_WAIT;
        else if (halt_req) state_next = DRAIN;
      end
      MEM_WAIT: begin
        if (!mw) state_next = RUN;
      end
      DRAIN: begin
        if (!halt_req) begin
          state_next = RUN;
        end else if (act == ACT_BUBBLE) begin
          if (drain_inc == DW'(DRAIN_CYCLES)) state_next = HALTED;
          else                                drain_next = drain_inc;
        end else begin
          drain_next = drain_reg;
        end
      end
      HALTED: begin
        if (!halt_req) state_next = RUN;
      end
      default: state_next = RUN;
    endcase

    // Watchdog saturates at its limit so a long freeze keeps timeout asserted.
    if (!mw)                                  wait_next = '0;
    else if (wait_reg != WW'(TIMEOUT_CYCLES)) wait_next = wait_reg + 1'b1;
    else                                      wait_next = wait_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= RUN;
      drain_reg    <= '0;
      wait_reg     <= '0;
      halt_ack_reg <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      drain_reg    <= drain_next;
      wait_reg     <= wait_next;
      halt_ack_reg <= (state_next == HALTED);
      if (clr_counters)
        timeout_reg <= 1'b0;
      else if (mw && (wait_next == WW'(TIMEOUT_CYCLES)))
        timeout_reg <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (act == ACT_STALL),
    .clr   (clr_counters),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (act == ACT_FLUSH),
    .clr   (clr_counters),
    .count (flush_count)
  );

  assign state       = state_reg;
  assign halt_ack    = halt_ack_reg;
  assign mem_timeout = timeout_reg;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed self-checking bench: load-use, memory wait, halt drain, watchdog,
// counter saturation/clear and asynchronous reset behaviour.
module tb_pipeline_hazard_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       halt_req = 1'b0;
  logic       clr_counters = 1'b0;
  logic       halt_ack;
  logic       mem_timeout;
  logic [1:0] stall_count;
  logic [1:0] flush_count;
  logic [1:0] state;

  int n_checks = 0;
  int n_errors = 0;

  pipeline_hazard_controller_if hz();

  pipeline_hazard_controller #(
    .CNT_W          (2),
    .TIMEOUT_CYCLES (8),
    .DRAIN_CYCLES   (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hz           (hz),
    .halt_req     (halt_req),
    .clr_counters (clr_counters),
    .halt_ack     (halt_ack),
    .mem_timeout  (mem_timeout),
    .stall_count  (stall_count),
    .flush_count  (flush_count),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    hz.MemRead_IDEX = 1'b0;
    hz.rd_IDEX      = 5'd0;
    hz.rs1_IFID     = 5'd0;
    hz.rs2_IFID     = 5'd0;
    hz.PCSrcE       = 1'b0;
    hz.dmem_req     = 1'b0;
    hz.dmem_ready   = 1'b0;
    halt_req        = 1'b0;
    clr_counters    = 1'b0;
  endtask

  task automatic check_ctrl(input string tag, input logic [4:0] exp);
    // order: PCWrite, Write_IFID, Flush_IFID, Flush_IDEX, freeze_all
    check_eq(tag, {hz.PCWrite, hz.Write_IFID, hz.Flush_IFID, hz.Flush_IDEX, hz.freeze_all}, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    #3;
    check_eq("rst_state", state, 0);
    check_eq("rst_halt_ack", halt_ack, 0);
    check_eq("rst_timeout", mem_timeout, 0);
    check_eq("rst_stall_cnt", stall_count, 0);
    check_eq("rst_flush_cnt", flush_count, 0);
    check_ctrl("rst_ctrl_run", 5'b11000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // load-use on rs2
    hz.MemRead_IDEX = 1'b1; hz.rd_IDEX = 5'd5; hz.rs2_IFID = 5'd5;
    @(negedge clk); check_ctrl("lu_ctrl", 5'b00010);
    step(); idle_inputs();
    check_eq("lu_stall_cnt", stall_count, 1);
    @(negedge clk); check_ctrl("lu_one_cycle", 5'b11000);
    step();
    hz.MemRead_IDEX = 1'b1; hz.rd_IDEX = 5'd0; hz.rs1_IFID = 5'd0;
    @(negedge clk); check_ctrl("lu_x0_ctrl", 5'b11000);
    step(); idle_inputs();
    check_eq("lu_x0_cnt", stall_count, 1);

    // memory wait with a taken branch held across it
    hz.dmem_req = 1'b1; hz.PCSrcE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_ctrl($sformatf("mw_freeze_%0d", i), 5'b00001);
      check_eq($sformatf("mw_state_%0d", i), state, (i == 0) ? 0 : 1);
      step();
    end
    hz.dmem_ready = 1'b1;
    @(negedge clk);
    check_ctrl("mw_ready_flush", 5'b11110);
    check_eq("mw_ready_state", state, 1);
    step(); idle_inputs();
    check_eq("mw_back_run", state, 0);
    check_eq("mw_flush_cnt", flush_count, 1);

    // mw + br + lu together: freeze only, no counts
    hz.dmem_req = 1'b1; hz.PCSrcE = 1'b1;
    hz.MemRead_IDEX = 1'b1; hz.rd_IDEX = 5'd7; hz.rs1_IFID = 5'd7;
    @(negedge clk); check_ctrl("sim_freeze_only", 5'b00001);
    step(); idle_inputs();
    check_eq("sim_state", state, 1);
    check_eq("sim_stall_cnt", stall_count, 1);
    check_eq("sim_flush_cnt", flush_count, 1);
    step();
    check_eq("sim_back_run", state, 0);

    // halt sequence
    halt_req = 1'b1;
    @(negedge clk);
    check_eq("halt_c1_state", state, 0);
    check_ctrl("halt_c1_ctrl", 5'b11000);
    step();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq($sformatf("drain_state_%0d", i), state, 2);
      check_ctrl($sformatf("drain_ctrl_%0d", i), 5'b01100);
      check_eq($sformatf("drain_ack_%0d", i), halt_ack, 0);
      step();
    end
    @(negedge clk);
    check_eq("halted_state", state, 3);
    check_eq("halted_ack", halt_ack, 1);
    check_ctrl("halted_ctrl", 5'b00010);
    step();
    halt_req = 1'b0;
    @(negedge clk);
    check_eq("halted_ack_hold", halt_ack, 1);
    step();
    check_eq("unhalt_state", state, 0);
    check_eq("unhalt_ack", halt_ack, 0);

    // branch in DRAIN updates PC without aborting; dropping halt_req aborts
    halt_req = 1'b1;
    step();
    hz.PCSrcE = 1'b1;
    @(negedge clk);
    check_eq("drain_br_state", state, 2);
    check_ctrl("drain_br_ctrl", 5'b11110);
    step(); hz.PCSrcE = 1'b0;
    check_eq("drain_br_stays", state, 2);
    halt_req = 1'b0;
    step();
    check_eq("drain_abort", state, 0);

    // watchdog: 10 cycles of unready memory
    hz.dmem_req = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check_eq($sformatf("to_freeze_%0d", k), hz.freeze_all, 1);
      step();
      check_eq($sformatf("to_flag_%0d", k), mem_timeout, (k >= 8) ? 1 : 0);
    end
    hz.dmem_ready = 1'b1;
    step(); idle_inputs();
    check_eq("to_run", state, 0);
    step();
    check_eq("to_sticky", mem_timeout, 1);

    // saturation of a 2-bit stall counter, then clear over increment
    hz.MemRead_IDEX = 1'b1; hz.rd_IDEX = 5'd9; hz.rs1_IFID = 5'd9;
    for (int k = 1; k <= 5; k++) begin
      step();
      check_eq($sformatf("sat_stall_%0d", k), stall_count, ((1 + k) > 3) ? 3 : (1 + k));
    end
    clr_counters = 1'b1;
    step(); clr_counters = 1'b0; idle_inputs();
    check_eq("clr_stall", stall_count, 0);
    check_eq("clr_flush", flush_count, 0);
    check_eq("clr_timeout", mem_timeout, 0);

    // asynchronous reset mid-DRAIN after two bubble cycles
    halt_req = 1'b1;
    step(); step(); step();
    check_eq("pre_rst_drain", state, 2);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_drain_state", state, 0);
    check_eq("arst_drain_ack", halt_ack, 0);
    check_ctrl("arst_drain_ctrl", 5'b11000);
    halt_req = 1'b0;
    step(); rst_n = 1'b1;

    // asynchronous reset while HALTED drops halt_ack without an edge
    halt_req = 1'b1;
    repeat (6) step();
    check_eq("pre_rst_halted", state, 3);
    check_eq("pre_rst_ack", halt_ack, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_halt_state", state, 0);
    check_eq("arst_halt_ack", halt_ack, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
